// File: rtl/barrett_modmul_pipe.sv
// Four-stage Barrett modular mul/add/sub unit for the NTT datapath.
// Accepts one operation per cycle; valid, tag and range-error travel alongside the data.
module barrett_modmul_pipe #(
  parameter int unsigned DATA_WIDTH = 14,
  parameter int unsigned Q          = 12289,
  parameter int unsigned MU         = (2 ** (2 * DATA_WIDTH)) / Q,
  parameter int unsigned TAG_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall,
  input  logic                  in_valid,
  input  logic [1:0]            in_op,
  input  logic [DATA_WIDTH-1:0] in_a,
  input  logic [DATA_WIDTH-1:0] in_b,
  input  logic [TAG_WIDTH-1:0]  in_tag,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [TAG_WIDTH-1:0]  out_tag,
  output logic                  out_err
);

  localparam int unsigned W = DATA_WIDTH;

  localparam logic [W-1:0]   Q_W  = W'(Q);
  localparam logic [W:0]     Q_E  = (W+1)'(Q);
  localparam logic [W+1:0]   Q_R  = (W+2)'(Q);
  localparam logic [2*W-1:0] Q_Z  = (2*W)'(Q);
  localparam logic [W:0]     MU_E = (W+1)'(MU);

  // Stage 1: operand combine
  logic [W:0]     a_e, b_e;
  logic [2*W-1:0] z1_d, z1_q;
  logic           err1_d;

  assign a_e = {1'b0, in_a};
  assign b_e = {1'b0, in_b};

  always_comb begin
    z1_d = '0;
    unique case (in_op)
      2'b01:   z1_d = (2*W)'(a_e + b_e);
      2'b10:   z1_d = (2*W)'(a_e + (Q_E - b_e));
      default: z1_d = (2*W)'(in_a) * (2*W)'(in_b);
    endcase
  end

  assign err1_d = (in_a >= Q_W) || (in_b >= Q_W);

  // Stages 2 and 3: quotient estimate, then quotient times modulus
  logic [2*W:0]   m2_d, m2_q;
  logic [2*W-1:0] z2_q;
  logic [2*W-1:0] m3_d, m3_q;
  logic [2*W-1:0] z3_q;

  assign m2_d = (2*W+1)'(z1_q >> (W-1)) * (2*W+1)'(MU_E);
  assign m3_d = (2*W)'(m2_q >> (W+1)) * Q_Z;

  // Stage 4: residue is below 3Q, so two conditional subtracts land in [0, Q)
  logic [W+1:0]   r_d, r1_d, r2_d;
  logic [W-1:0]   out_data_d, out_data_q;

  always_comb begin
    r_d  = (W+2)'(z3_q) - (W+2)'(m3_q);
    r1_d = (r_d  >= Q_R) ? (r_d  - Q_R) : r_d;
    r2_d = (r1_d >= Q_R) ? (r1_d - Q_R) : r1_d;
    out_data_d = W'(r2_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      z1_q       <= '0;
      m2_q       <= '0;
      z2_q       <= '0;
      m3_q       <= '0;
      z3_q       <= '0;
      out_data_q <= '0;
    end else if (!stall) begin
      z1_q       <= z1_d;
      m2_q       <= m2_d;
      z2_q       <= z1_q;
      m3_q       <= m3_d;
      z3_q       <= z2_q;
      out_data_q <= out_data_d;
    end
  end

  // Sideband shift registers; index 0 is stage 1, index 3 drives the outputs
  logic [3:0]                 vld_q;
  logic [3:0][TAG_WIDTH-1:0]  tag_q;
  logic [3:0]                 err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      tag_q <= '0;
      err_q <= '0;
    end else if (!stall) begin
      vld_q <= {vld_q[2:0], in_valid};
      tag_q <= {tag_q[2:0], in_tag};
      err_q <= {err_q[2:0], err1_d};
    end
  end

  assign out_valid = vld_q[3];
  assign out_tag   = tag_q[3];
  assign out_err   = err_q[3];
  assign out_data  = out_data_q;

endmodule
